// File: rtl/ibridge_pkg.sv
// Shared types and AXI constants for the instruction-fetch AXI read bridge.
package ibridge_pkg;

  typedef enum logic {
    AR_IDLE = 1'b0,
    AR_SEND = 1'b1
  } ar_state_e;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/ibridge_outstanding_ctr.sv
// Outstanding-read counter: increments on accept, decrements on returned data,
// with guards so it can neither exceed MAX nor wrap below zero.
module ibridge_outstanding_ctr #(
  parameter int MAX = 2,
  localparam int W  = $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic nonzero
);

  logic [W-1:0] cnt;
  logic         inc_ok;
  logic         dec_ok;

  assign full    = (cnt == W'(MAX));
  assign nonzero = (cnt != '0);
  assign inc_ok  = inc & ~full;
  assign dec_ok  = dec & nonzero;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (inc_ok && !dec_ok) begin
      cnt <= cnt + 1'b1;
    end else if (dec_ok && !inc_ok) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/inst_axi_rd_bridge.sv
// Fetch-side SRAM-like request/response to AXI4 read master, in-order, single ARID.
// Optional sticky read-error flag enabled by macro IBRIDGE_RESP_ERR_EN.
//
// state   | meaning
// AR_IDLE | no address pending; may accept a fetch request
// AR_SEND | araddr/arsize latched, arvalid high until arready
module inst_axi_rd_bridge
  import ibridge_pkg::*;
#(
  parameter int         MAX_OUTSTANDING = 2,
  parameter logic [3:0] AXI_ID          = 4'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic        bus_err
);

  ar_state_e state, state_nxt;
  logic      full;
  logic      nonzero;
  logic      accept;

  assign arid    = AXI_ID;
  assign arlen   = 8'd0;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;

  assign inst_sram_addr_ok = ~reset & (state == AR_IDLE) & inst_sram_req & ~inst_sram_wr & ~full;
  assign accept            = inst_sram_req & inst_sram_addr_ok;
  assign arvalid           = (state == AR_SEND);

  // rready gated by nonzero keeps the counter from underflowing on stray beats
  assign rready            = ~reset & nonzero;
  assign inst_sram_data_ok = rvalid & rready;
  assign inst_sram_rdata   = rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= AR_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      AR_IDLE: if (accept) state_nxt = AR_SEND;
      AR_SEND: if (arready) state_nxt = AR_IDLE;
      default: state_nxt = AR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      araddr <= 32'd0;
      arsize <= 3'd0;
    end else if (accept) begin
      araddr <= inst_sram_addr;
      arsize <= {1'b0, inst_sram_size};
    end
  end

  ibridge_outstanding_ctr #(
    .MAX(MAX_OUTSTANDING)
  ) u_ctr (
    .clk    (clk),
    .reset  (reset),
    .inc    (accept),
    .dec    (inst_sram_data_ok),
    .full   (full),
    .nonzero(nonzero)
  );

`ifdef IBRIDGE_RESP_ERR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      bus_err <= 1'b0;
    end else if (inst_sram_data_ok &&
                 (rresp == AXI_RESP_SLVERR || rresp == AXI_RESP_DECERR)) begin
      bus_err <= 1'b1;
    end
  end

  logic unused_in;
  assign unused_in = ^{inst_sram_wstrb, inst_sram_wdata, rid, rlast};
`else
  assign bus_err = 1'b0;

  // Inputs kept on the port list for a fixed interface but not consumed here
  logic unused_in;
  assign unused_in = ^{inst_sram_wstrb, inst_sram_wdata, rid, rlast, rresp};
`endif

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// Directed bench for inst_axi_rd_bridge with queue-based scoreboard and monitor.
module tb_inst_axi_rd_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr, wdata;
  logic        addr_ok, data_ok;
  logic [31:0] sram_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready, bus_err;

  int total = 0;
  int bad   = 0;

  logic [34:0] exp_ar[$];
  logic [31:0] exp_r[$];

  always #5 clk = ~clk;

  inst_axi_rd_bridge dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(req), .inst_sram_wr(wr), .inst_sram_size(size),
    .inst_sram_wstrb(wstrb), .inst_sram_addr(addr), .inst_sram_wdata(wdata),
    .inst_sram_addr_ok(addr_ok), .inst_sram_data_ok(data_ok), .inst_sram_rdata(sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .bus_err(bus_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, expv);
    end
  endtask

  // Monitor: every AR handshake and every data_ok is matched against the queues
  always @(negedge clk) begin
    if (!reset) begin
      if (arvalid && arready) begin
        total++;
        if (exp_ar.size() == 0) begin
          bad++;
          $display("FAIL ar_unexpected araddr=%h", araddr);
        end else begin
          logic [34:0] e;
          e = exp_ar.pop_front();
          if ({arsize, araddr} !== e || arid !== 4'd0 || arlen !== 8'd0 || arburst !== 2'b01) begin
            bad++;
            $display("FAIL ar_beat got size=%h addr=%h want size=%h addr=%h",
                     arsize, araddr, e[34:32], e[31:0]);
          end
        end
      end
      if (data_ok) begin
        total++;
        if (exp_r.size() == 0) begin
          bad++;
          $display("FAIL r_unexpected rdata=%h", sram_rdata);
        end else begin
          logic [31:0] d;
          d = exp_r.pop_front();
          if (sram_rdata !== d) begin
            bad++;
            $display("FAIL r_beat got=%h want=%h", sram_rdata, d);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [1:0] sz);
    bit done;
    done = 1'b0;
    req = 1'b1; wr = 1'b0; addr = a; size = sz;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (addr_ok) begin
        exp_ar.push_back({1'b0, sz, a});
        done = 1'b1;
      end
      step();
    end
    req = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL issue_timeout addr=%h got=no_accept want=accept", a);
    end
  endtask

  task automatic rbeat(input logic [31:0] d, input logic [1:0] resp);
    rvalid = 1'b1; rdata = d; rresp = resp;
    exp_r.push_back(d);
    @(negedge clk);
    chk("data_ok_on_rvalid", {31'd0, data_ok}, 32'd1);
    step();
    rvalid = 1'b0; rresp = 2'b00;
  endtask

  initial begin
    reset = 1'b1; req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h1C00_0000;
    wstrb = 4'hF; wdata = 32'h0; arready = 1'b0; rid = 4'd0; rdata = 32'h0;
    rresp = 2'b00; rlast = 1'b1; rvalid = 1'b1;
    step(); step();
    @(negedge clk);
    chk("reset_addr_ok", {31'd0, addr_ok}, 32'd0);
    chk("reset_rready", {31'd0, rready}, 32'd0);
    chk("reset_data_ok", {31'd0, data_ok}, 32'd0);
    step();
    reset = 1'b0; req = 1'b0; rvalid = 1'b0;
    @(negedge clk);
    chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
    chk("rst_araddr", araddr, 32'd0);
    chk("rst_arsize", {29'd0, arsize}, 32'd0);
    chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
    step();

    // single read
    arready = 1'b1;
    issue(32'h1C00_0000, 2'd2);
    @(negedge clk);
    chk("single_arvalid", {31'd0, arvalid}, 32'd1);
    chk("single_arsize", {29'd0, arsize}, 32'd2);
    step();
    rbeat(32'h0280_0000, 2'b00);
    @(negedge clk);
    chk("single_cnt_zero", {31'd0, rready}, 32'd0);
    step();

    // AR stall: 3 cycles of arready low, second request held meanwhile
    arready = 1'b0;
    issue(32'h1C00_0010, 2'd2);
    req = 1'b1; addr = 32'h1C00_0020; size = 2'd1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_arvalid", {31'd0, arvalid}, 32'd1);
      chk("stall_araddr", araddr, 32'h1C00_0010);
      chk("stall_addr_ok", {31'd0, addr_ok}, 32'd0);
      step();
    end
    arready = 1'b1;
    @(negedge clk);
    chk("stall_release_arvalid", {31'd0, arvalid}, 32'd1);
    chk("stall_release_addr_ok", {31'd0, addr_ok}, 32'd0);
    step();
    @(negedge clk);
    chk("stall_next_addr_ok", {31'd0, addr_ok}, 32'd1);
    if (addr_ok) exp_ar.push_back({1'b0, 2'd1, 32'h1C00_0020});
    step();
    req = 1'b0;
    rbeat(32'h0000_00A1, 2'b00);
    rbeat(32'h0000_00A2, 2'b00);

    // outstanding limit of 2
    issue(32'h0000_1000, 2'd2);
    issue(32'h0000_1004, 2'd2);
    req = 1'b1; addr = 32'h0000_1008; size = 2'd2;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("limit_addr_ok", {31'd0, addr_ok}, 32'd0);
      step();
    end
    rbeat(32'h0000_C001, 2'b00);
    @(negedge clk);
    chk("limit_reopen_addr_ok", {31'd0, addr_ok}, 32'd1);
    if (addr_ok) exp_ar.push_back({1'b0, 2'd2, 32'h0000_1008});
    step();
    req = 1'b0;
    rbeat(32'h0000_C002, 2'b00);
    rbeat(32'h0000_C003, 2'b00);
    @(negedge clk);
    chk("limit_drained", {31'd0, rready}, 32'd0);
    step();

    // simultaneous accept and data_ok at cnt=1
    issue(32'h0000_0100, 2'd2);
    step();
    req = 1'b1; addr = 32'h0000_0104; size = 2'd2;
    rvalid = 1'b1; rdata = 32'h0000_000A;
    exp_r.push_back(32'h0000_000A);
    @(negedge clk);
    chk("simul_addr_ok", {31'd0, addr_ok}, 32'd1);
    chk("simul_data_ok", {31'd0, data_ok}, 32'd1);
    if (addr_ok) exp_ar.push_back({1'b0, 2'd2, 32'h0000_0104});
    step();
    req = 1'b0; rvalid = 1'b0;
    @(negedge clk);
    chk("simul_cnt_one", {31'd0, rready}, 32'd1);
    step();
    rbeat(32'h0000_000B, 2'b00);
    @(negedge clk);
    chk("simul_cnt_zero", {31'd0, rready}, 32'd0);
    step();

    // write requests never accepted; spurious rvalid ignored
    req = 1'b1; wr = 1'b1; addr = 32'h0000_2000;
    rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("wr_addr_ok", {31'd0, addr_ok}, 32'd0);
      chk("wr_arvalid", {31'd0, arvalid}, 32'd0);
      chk("spurious_rready", {31'd0, rready}, 32'd0);
      chk("spurious_data_ok", {31'd0, data_ok}, 32'd0);
      step();
    end
    req = 1'b0; wr = 1'b0; rvalid = 1'b0;

    // error response handling
    issue(32'h0000_3000, 2'd2);
    step();
    rbeat(32'h0000_E001, 2'b10);
    @(negedge clk);
`ifdef IBRIDGE_RESP_ERR_EN
    chk("err_set", {31'd0, bus_err}, 32'd1);
`else
    chk("err_disabled", {31'd0, bus_err}, 32'd0);
`endif
    step();
    issue(32'h0000_3004, 2'd2);
    step();
    rbeat(32'h0000_E002, 2'b00);
    @(negedge clk);
`ifdef IBRIDGE_RESP_ERR_EN
    chk("err_sticky", {31'd0, bus_err}, 32'd1);
`else
    chk("err_disabled_okay", {31'd0, bus_err}, 32'd0);
`endif
    step();

    // reset mid-flight: arvalid stalled with one read outstanding
    arready = 1'b0;
    issue(32'h0000_4000, 2'd2);
    @(negedge clk);
    chk("midflight_arvalid", {31'd0, arvalid}, 32'd1);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_ar.delete();
    rvalid = 1'b1; rdata = 32'h5A5A_5A5A;
    @(negedge clk);
    chk("midrst_arvalid", {31'd0, arvalid}, 32'd0);
    chk("midrst_rready", {31'd0, rready}, 32'd0);
    chk("midrst_data_ok", {31'd0, data_ok}, 32'd0);
    chk("midrst_bus_err", {31'd0, bus_err}, 32'd0);
    step();
    rvalid = 1'b0; arready = 1'b1;
    step();

    chk("ar_queue_empty", exp_ar.size(), 32'd0);
    chk("r_queue_empty", exp_r.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_axi_rd_bridge.md
# inst_axi_rd_bridge

Converts the instruction-fetch stage's SRAM-like request/response protocol (req, addr_ok, data_ok) into an AXI4 read-only master. It sits directly upstream of the fetch stage: the fetch stage drives `inst_sram_*` requests into it, and it returns `addr_ok`/`data_ok`/`rdata`. Several reads may be in flight at once, and responses return in issue order on a single fixed ARID. Write requests are never accepted on this port.

## Interface
- `MAX_OUTSTANDING`, default 2: maximum number of accepted requests whose data has not yet returned (1..7).
- `AXI_ID`, default 4'd0: constant value driven on `arid`.
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high; clock `clk`.
- `inst_sram_req` in 1: fetch request; held high until `addr_ok`.
- `inst_sram_wr` in 1: write flag; a request with `inst_sram_wr`=1 is never accepted.
- `inst_sram_size` in 2: byte-size code (0=1B, 1=2B, 2=4B); passed to `arsize`.
- `inst_sram_wstrb` in 4: ignored.
- `inst_sram_addr` in 32: physical fetch address.
- `inst_sram_wdata` in 32: ignored.
- `inst_sram_addr_ok` out 1: request accepted this cycle.
- `inst_sram_data_ok` out 1: `inst_sram_rdata` valid this cycle.
- `inst_sram_rdata` out 32: returned instruction word.
- `arid` out 4: always `AXI_ID`.
- `araddr` out 32: registered address.
- `arlen` out 8: always 0.
- `arsize` out 3: {1'b0, size}.
- `arburst` out 2: always 2'b01.
- `arlock` out 2: always 0.
- `arcache` out 4: always 0.
- `arprot` out 3: always 0.
- `arvalid` out 1: AR channel valid.
- `arready` in 1: AR channel ready.
- `rid` in 4: ignored.
- `rdata` in 32: R channel data.
- `rresp` in 2: R channel response.
- `rlast` in 1: ignored, because `arlen` is 0.
- `rvalid` in 1: R channel valid.
- `rready` out 1: R channel ready.
- `bus_err` out 1: sticky read-error flag (see Configuration).

## Operation
- AR FSM has two states, `AR_IDLE` and `AR_SEND`.
- `addr_ok` = !reset & state==AR_IDLE & req & !wr & cnt<MAX_OUTSTANDING.
- Accept = req & addr_ok.
  - On accept: latch `araddr`←addr and `arsize`←{0,size}, then go to `AR_SEND`.
- `arvalid` = (state==AR_SEND).
  - `araddr`/`arsize` are stable while `arvalid` is high.
  - On `arvalid & arready`, go to `AR_IDLE`.
- `cnt` tracks outstanding requests (width clog2(MAX_OUTSTANDING+1)).
  - +1 on accept; −1 on `data_ok`.
  - Both in the same cycle: `cnt` is unchanged.
  - `cnt` never overflows, because `addr_ok` is gated by the limit.
  - `cnt` never underflows, because `rready` is gated by cnt≠0.
- `rready` = (cnt≠0).
- `data_ok` = rvalid & rready.
- `inst_sram_rdata` = `rdata`, combinational pass-through.
- An `rvalid` arriving with cnt==0 is not accepted and produces no `data_ok`.
- Fetch-side cancellation is handled entirely in the fetch stage: every accepted request produces exactly one `data_ok`, in issue order.
- Reset values: state `AR_IDLE`, `arvalid`=0, `araddr`=0, `arsize`=0, `cnt`=0, `bus_err`=0.
  - `addr_ok`/`data_ok`/`rready` are 0 while `reset` is high.
- Reset mid-operation abandons all in-flight reads.
  - Stale R beats arriving after reset are not accepted, because `rready` is 0 while cnt=0.

## Timing
- Accept in cycle N → `arvalid` high from N+1.
- If `arready` is high in N+1, the next `addr_ok` can occur in N+2, giving peak throughput of one request per 2 cycles.
- `data_ok` is combinational with `rvalid`, so there is zero added latency on the R path.
  - Earliest `data_ok` for a request accepted at N is N+2, if the slave returns `rvalid` in the cycle after the AR handshake.
- `arvalid` held for K cycles of `arready`=0: no new `addr_ok` during that time, and `araddr` is stable.

## Configuration
- Macro: `IBRIDGE_RESP_ERR_EN`.
- Defined: `bus_err` is set on any `data_ok` with `rresp[1]`=1 (SLVERR/DECERR) and cleared only by reset. Data is still returned with `data_ok`.
- Undefined: `bus_err` is tied to 0 and `rresp` is unused. The port list is identical in both cases.

## Structure
- Shared package `ibridge_pkg` holds:
  - AR state encodings;
  - `AXI_BURST_INCR`=2'b01;
  - `AXI_RESP_OKAY`=2'b00, `AXI_RESP_SLVERR`=2'b10, `AXI_RESP_DECERR`=2'b11.
- One sub-module, `ibridge_outstanding_ctr`: the up/down saturating-guarded counter with `full`/`nonzero` outputs.

## Test plan
- Single read: req, addr=0x1C000000, size=2, `arready`=1, then `rvalid` 2 cycles later with rdata=0x02800000 → `araddr`=0x1C000000, `arsize`=3'b010, exactly one `data_ok` carrying 0x02800000, cnt returns to 0.
- `arready` held low 3 cycles → `arvalid` stays high with constant `araddr` and no `addr_ok` during the stall; handshake happens on the 4th cycle.
- Outstanding limit (MAX_OUTSTANDING=2): three back-to-back requests, no `rvalid` → 2 accepts, third `req` held with `addr_ok`=0; one `rvalid` → third request accepted next eligible cycle.
- Simultaneous accept and `data_ok` with cnt=1 → cnt stays 1; responses arrive in order 0xA, 0xB with no loss.
- `wr`=1 with `req`=1 → `addr_ok` stays 0 and `arvalid` never rises. Spurious `rvalid` with cnt=0 → `rready`=0 and no `data_ok`.
- With `IBRIDGE_RESP_ERR_EN`: `rresp`=2'b10 on a `data_ok` → `bus_err`=1 and stays 1 through later OKAY responses until reset. Reset asserted mid-flight → cnt=0, `arvalid`=0, `bus_err`=0 the cycle after.
